// File: rtl/cpld_pkg.sv
// Shared definitions for the DSP boot monitor: the supervisor state encoding
// and the default timing constants for a 25 MHz system clock.
package cpld_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_STAT,
        ST_OK,
        ST_RETRY,
        ST_DRAIN,
        ST_FAIL
    } bootState_e;

    // 40 ms at 25 MHz from full-reset release to a debounced RESETSTAT# high
    localparam logic [19:0] DEF_BOOT_TIMEOUT = 20'hF_4240;
    localparam logic [3:0]  DEF_DEB_LEN      = 4'd8;
    localparam logic [1:0]  DEF_MAX_RETRY    = 2'd2;
    localparam logic [7:0]  DEF_REQ_LEN      = 8'd16;
    // 250 ms slow-blink half period; the fast blink uses a quarter of it
    localparam logic [23:0] DEF_LED_HALF     = 24'h5F_5E10;

    // States in which the status LED blinks rather than sitting steady
    function automatic logic isBlinkState(input bootState_e s);
        return (s == ST_WAIT_STAT) || (s == ST_RETRY) || (s == ST_FAIL);
    endfunction

endpackage

// File: rtl/dsp_boot_monitor_if.sv
// Signal bundle between the reset sequencer / DSP and the boot monitor.
// The monitor is the master: it owns the request and status outputs.
interface dsp_boot_monitor_if;

    logic       rstfull_n_in;
    logic       dsp0_rstn_state;
    logic       reboot_req;
    logic       boot_ok;
    logic       boot_fail;
    logic [1:0] retry_cnt;
    logic       dsp_led_0;

    modport master (
        input  rstfull_n_in,
        input  dsp0_rstn_state,
        output reboot_req,
        output boot_ok,
        output boot_fail,
        output retry_cnt,
        output dsp_led_0
    );

    modport slave (
        output rstfull_n_in,
        output dsp0_rstn_state,
        input  reboot_req,
        input  boot_ok,
        input  boot_fail,
        input  retry_cnt,
        input  dsp_led_0
    );

endinterface

// File: rtl/sync_debounce.sv
// Brings an asynchronous status line into the clock domain and reports when
// it has been seen high for DEB_LEN consecutive synchronized samples.
module sync_debounce
    import cpld_pkg::*;
#(
    parameter logic [3:0] DEB_LEN = DEF_DEB_LEN
) (
    input  logic clk_sys,
    input  logic hard_rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic deb_hi_o
);

    logic [1:0] sync_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Two-flop synchronizer; only the second stage is used downstream
    always_ff @(posedge clk_sys or negedge hard_rst_n) begin
        if (!hard_rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], async_i};
        end
    end

    // Run length of high samples: any low sample restarts it, and it parks at DEB_LEN
    always_comb begin
        cnt_d = cnt_q;
        if (!sync_q[1]) begin
            cnt_d = 4'd0;
        end else if (cnt_q != DEB_LEN) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Register the run length
    always_ff @(posedge clk_sys or negedge hard_rst_n) begin
        if (!hard_rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sync_o   = sync_q[1];
    assign deb_hi_o = (cnt_q == DEB_LEN);

endmodule

// File: rtl/dsp_boot_monitor.sv
// DSP boot supervisor: after the sequencer releases full reset it waits for
// the DSP to report out-of-reset, asks the sequencer to reboot on a timeout,
// gives up after MAX_RETRY reboots, and shows progress on a status LED.
module dsp_boot_monitor
    import cpld_pkg::*;
#(
    parameter logic [19:0] BOOT_TIMEOUT = DEF_BOOT_TIMEOUT,
    parameter logic [3:0]  DEB_LEN      = DEF_DEB_LEN,
    parameter logic [1:0]  MAX_RETRY    = DEF_MAX_RETRY,
    parameter logic [7:0]  REQ_LEN      = DEF_REQ_LEN,
    parameter logic [23:0] LED_HALF     = DEF_LED_HALF
) (
    input  logic              clk_sys,
    input  logic              hard_rst_n,
    dsp_boot_monitor_if.master bus
);

    localparam logic [23:0] FAST_HALF = LED_HALF >> 2;

    logic [1:0]  rfSync_q;
    logic        rfS;
    logic        stS;
    logic        debHi;

    bootState_e  state_q;
    bootState_e  prevState_q;
    logic [19:0] timeoutCnt_q;
    logic [7:0]  reqCnt_q;
    logic [23:0] blinkCnt_q;
    logic [1:0]  retryCnt_q;
    logic        rebootReq_q;
    logic        bootOk_q;
    logic        bootFail_q;
    logic        led_q;
    logic [23:0] blinkHalf;

    // Full-reset release only needs a plain two-flop synchronizer
    always_ff @(posedge clk_sys or negedge hard_rst_n) begin
        if (!hard_rst_n) begin
            rfSync_q <= 2'b00;
        end else begin
            rfSync_q <= {rfSync_q[0], bus.rstfull_n_in};
        end
    end

    assign rfS = rfSync_q[1];

    sync_debounce #(
        .DEB_LEN (DEB_LEN)
    ) u_statDebounce (
        .clk_sys    (clk_sys),
        .hard_rst_n (hard_rst_n),
        .async_i    (bus.dsp0_rstn_state),
        .sync_o     (stS),
        .deb_hi_o   (debHi)
    );

    assign blinkHalf = (state_q == ST_FAIL) ? FAST_HALF : LED_HALF;

    // Supervisor FSM with its counters and registered outputs; the outputs
    // follow the state register one cycle later, and the blink counter
    // restarts on the first cycle that sees a new state
    always_ff @(posedge clk_sys or negedge hard_rst_n) begin
        if (!hard_rst_n) begin
            state_q      <= ST_IDLE;
            prevState_q  <= ST_IDLE;
            timeoutCnt_q <= 20'd0;
            reqCnt_q     <= 8'd0;
            blinkCnt_q   <= 24'd0;
            retryCnt_q   <= 2'd0;
            rebootReq_q  <= 1'b0;
            bootOk_q     <= 1'b0;
            bootFail_q   <= 1'b0;
            led_q        <= 1'b0;
        end else begin
            prevState_q <= state_q;
            rebootReq_q <= (state_q == ST_RETRY);
            bootOk_q    <= (state_q == ST_OK);
            bootFail_q  <= (state_q == ST_FAIL);

            if (state_q != prevState_q) begin
                blinkCnt_q <= 24'd0;
                led_q      <= (state_q == ST_OK);
            end else if (isBlinkState(state_q)) begin
                if (blinkCnt_q == blinkHalf - 24'd1) begin
                    blinkCnt_q <= 24'd0;
                    led_q      <= ~led_q;
                end else begin
                    blinkCnt_q <= blinkCnt_q + 24'd1;
                end
            end else begin
                blinkCnt_q <= 24'd0;
                led_q      <= (state_q == ST_OK);
            end

            case (state_q)
                ST_IDLE: begin
                    if (rfS) begin
                        state_q      <= ST_WAIT_STAT;
                        timeoutCnt_q <= 20'd0;
                    end
                end
                ST_WAIT_STAT: begin
                    timeoutCnt_q <= timeoutCnt_q + 20'd1;
                    if (!rfS) begin
                        state_q <= ST_IDLE;
                    end else if (debHi) begin
                        state_q <= ST_OK;
                    end else if (timeoutCnt_q == BOOT_TIMEOUT - 20'd1) begin
                        if (retryCnt_q < MAX_RETRY) begin
                            state_q  <= ST_RETRY;
                            reqCnt_q <= 8'd0;
                            if (retryCnt_q != 2'd3) begin
                                retryCnt_q <= retryCnt_q + 2'd1;
                            end
                        end else begin
                            state_q <= ST_FAIL;
                        end
                    end
                end
                ST_OK: begin
                    if (!rfS) begin
                        state_q <= ST_IDLE;
                    end else if (!stS) begin
                        state_q      <= ST_WAIT_STAT;
                        timeoutCnt_q <= 20'd0;
                    end
                end
                ST_RETRY: begin
                    if (reqCnt_q == REQ_LEN - 8'd1) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        reqCnt_q <= reqCnt_q + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    if (!rfS) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_FAIL: begin
                    state_q <= ST_FAIL;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.reboot_req = rebootReq_q;
    assign bus.boot_ok    = bootOk_q;
    assign bus.boot_fail  = bootFail_q;
    assign bus.retry_cnt  = retryCnt_q;
    assign bus.dsp_led_0  = led_q;

endmodule

// File: tb/tb_dsp_boot_monitor.sv
// Scoreboard bench for dsp_boot_monitor: stimulus predicts each output event
// (reboot request, boot ok rise/fall, boot fail) with its cycle and retry
// count from the boot rules, and an independent monitor pops and compares.
module tb_dsp_boot_monitor;

    localparam int kTimeout  = 100;
    localparam int kDeb      = 4;
    localparam int kMaxRetry = 2;
    localparam int kReqLen   = 4;
    localparam int kHalf     = 16;

    localparam int EV_REQ    = 0;
    localparam int EV_OK     = 1;
    localparam int EV_OKFALL = 2;
    localparam int EV_BFAIL  = 3;

    typedef struct {
        int kind;
        int cycle;
        int retry;
    } expEvent_t;

    logic clk_sys = 1'b0;
    logic hard_rst_n;

    dsp_boot_monitor_if bus();

    dsp_boot_monitor #(
        .BOOT_TIMEOUT (20'd100),
        .DEB_LEN      (4'd4),
        .MAX_RETRY    (2'd2),
        .REQ_LEN      (8'd4),
        .LED_HALF     (24'd16)
    ) dut (
        .clk_sys    (clk_sys),
        .hard_rst_n (hard_rst_n),
        .bus        (bus)
    );

    // 25 MHz clock
    always #20 clk_sys = ~clk_sys;

    // Count rising edges so events can be timestamped in cycles
    int cycCnt = 0;
    always @(posedge clk_sys) cycCnt <= cycCnt + 1;

    expEvent_t expQ[$];
    int errors     = 0;
    int checks     = 0;
    int modelRetry = 0;
    int toggles    = 0;

    // Single comparison point shared by the monitor and the stimulus
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycCnt);
        end
    endtask

    // Match one observed output event against the oldest prediction
    task automatic reportEvent(input int kind);
        expEvent_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected event: got kind %0d at cycle %0d, expected none", kind, cycCnt);
        end else begin
            e = expQ.pop_front();
            checkOutput($sformatf("event kind (exp %0d)", e.kind), kind, e.kind);
            checkOutput($sformatf("event cycle (kind %0d)", e.kind), cycCnt, e.cycle);
            checkOutput($sformatf("retry_cnt at event (kind %0d)", e.kind), int'(bus.retry_cnt), e.retry);
        end
    endtask

    // Monitor: watch output edges on the falling clock edge, away from updates
    initial begin
        logic prevReq, prevOk, prevFail, prevLed;
        int   reqStart, lastToggle;
        prevReq = 1'b0; prevOk = 1'b0; prevFail = 1'b0; prevLed = 1'b0;
        reqStart = 0; lastToggle = -1;
        forever begin
            @(negedge clk_sys);
            if (!hard_rst_n) begin
                prevReq = 1'b0; prevOk = 1'b0; prevFail = 1'b0; prevLed = 1'b0;
                lastToggle = -1;
            end else begin
                if (bus.reboot_req && !prevReq) begin
                    reportEvent(EV_REQ);
                    reqStart = cycCnt;
                end
                if (!bus.reboot_req && prevReq)
                    checkOutput("reboot_req width", cycCnt - reqStart, kReqLen);
                if (bus.boot_ok && !prevOk) reportEvent(EV_OK);
                if (!bus.boot_ok && prevOk) reportEvent(EV_OKFALL);
                if (bus.boot_fail && !prevFail) reportEvent(EV_BFAIL);
                if (bus.boot_ok) checkOutput("led steady in OK", int'(bus.dsp_led_0), 1);
                if (bus.boot_fail) begin
                    if (bus.dsp_led_0 != prevLed) begin
                        if (lastToggle >= 0)
                            checkOutput("fail blink interval", cycCnt - lastToggle, kHalf / 4);
                        lastToggle = cycCnt;
                        toggles++;
                    end
                end else begin
                    lastToggle = -1;
                end
                prevReq  = bus.reboot_req;
                prevOk   = bus.boot_ok;
                prevFail = bus.boot_fail;
                prevLed  = bus.dsp_led_0;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Spend n cycles, optionally filling them with pulses too short to debounce;
    // the status line is always left low at the end
    task automatic waitWithGlitches(input int n, input bit enable);
        int rem = n;
        int len, gap;
        if (enable) begin
            while (rem >= 10) begin
                len = $urandom_range(1, kDeb - 1);
                gap = $urandom_range(1, 4);
                bus.dsp0_rstn_state = 1'b1;
                cycles(len);
                bus.dsp0_rstn_state = 1'b0;
                cycles(gap);
                rem -= len + gap;
            end
        end
        cycles(rem);
    endtask

    // One boot attempt from IDLE: release full reset, raise the DSP status
    // 'delay' cycles later (or never, if delay exceeds the timeout window).
    // Reference timing: full-reset release takes 2 sync cycles plus one
    // FSM edge to start the timeout window; a status rise needs 2 sync
    // cycles and DEB_LEN samples, then one FSM edge and one output register.
    // exitMode 1 additionally drops the DSP status while OK and re-boots.
    task automatic applyStimulus(input int delay, input bit glitch, input int exitMode);
        int  base, base2;
        bit  willOk;
        base   = cycCnt;
        willOk = (delay <= kTimeout - kDeb);
        bus.rstfull_n_in = 1'b1;
        if (willOk) begin
            expQ.push_back('{EV_OK, base + delay + 2 + kDeb + 2, modelRetry});
        end else if (modelRetry < kMaxRetry) begin
            modelRetry++;
            expQ.push_back('{EV_REQ, base + 3 + kTimeout + 1, modelRetry});
        end else begin
            expQ.push_back('{EV_BFAIL, base + 3 + kTimeout + 1, modelRetry});
        end

        if (willOk) begin
            waitWithGlitches(delay, glitch);
            bus.dsp0_rstn_state = 1'b1;
            cycles(12);
            if (exitMode == 1) begin
                base2 = cycCnt;
                bus.dsp0_rstn_state = 1'b0;
                expQ.push_back('{EV_OKFALL, base2 + 4, modelRetry});
                cycles(10);
                base2 = cycCnt;
                bus.dsp0_rstn_state = 1'b1;
                expQ.push_back('{EV_OK, base2 + 2 + kDeb + 2, modelRetry});
                cycles(12);
            end
            base2 = cycCnt;
            bus.rstfull_n_in    = 1'b0;
            bus.dsp0_rstn_state = 1'b0;
            expQ.push_back('{EV_OKFALL, base2 + 4, modelRetry});
            cycles(6);
        end else begin
            if (delay < kTimeout + 10) begin
                waitWithGlitches(delay, glitch);
                bus.dsp0_rstn_state = 1'b1;
                cycles(kTimeout + 12 - delay);
            end else begin
                waitWithGlitches(kTimeout + 12, glitch);
            end
            bus.dsp0_rstn_state = 1'b0;
            if (expQ.size() == 0 || modelRetry <= kMaxRetry) begin
                if (!bus.boot_fail) begin
                    bus.rstfull_n_in = 1'b0;
                    cycles(6);
                end
            end
        end
    endtask

    initial begin
        int base;
        hard_rst_n          = 1'b0;
        bus.rstfull_n_in    = 1'b0;
        bus.dsp0_rstn_state = 1'b0;
        cycles(3);

        checkOutput("reset reboot_req", int'(bus.reboot_req), 0);
        checkOutput("reset boot_ok", int'(bus.boot_ok), 0);
        checkOutput("reset boot_fail", int'(bus.boot_fail), 0);
        checkOutput("reset retry_cnt", int'(bus.retry_cnt), 0);
        checkOutput("reset dsp_led_0", int'(bus.dsp_led_0), 0);

        hard_rst_n = 1'b1;
        cycles(3);

        // Normal boot with the status 30 cycles after release
        applyStimulus(30, 1'b0, 0);

        // Random successful boots, some with sub-debounce glitches first
        for (int i = 0; i < 4; i++)
            applyStimulus($urandom_range(8, kTimeout - kDeb - 4), 1'($urandom_range(0, 1)), 0);

        // DSP drops back into reset while OK, then boots again
        applyStimulus(20, 1'b1, 1);

        // Debounce completing on the last timeout cycle still wins
        applyStimulus(kTimeout - kDeb, 1'b0, 0);

        // One cycle later is a timeout, then a glitch-only timeout, then failure
        applyStimulus(kTimeout - kDeb + 1, 1'b0, 0);
        applyStimulus(1000, 1'b1, 0);
        applyStimulus(1000, 1'b0, 0);
        cycles(40);
        checkOutput("fail blink toggles seen", int'(toggles >= 5), 1);
        checkOutput("boot_fail sticky", int'(bus.boot_fail), 1);
        checkOutput("no reboot_req in fail", int'(bus.reboot_req), 0);

        // Hard reset out of FAIL drops everything asynchronously
        #5 hard_rst_n = 1'b0;
        #1;
        checkOutput("async reset boot_fail", int'(bus.boot_fail), 0);
        checkOutput("async reset retry_cnt", int'(bus.retry_cnt), 0);
        modelRetry          = 0;
        bus.rstfull_n_in    = 1'b0;
        bus.dsp0_rstn_state = 1'b0;
        cycles(2);
        hard_rst_n = 1'b1;
        cycles(3);

        // Hard reset in the middle of a reboot request pulse
        base = cycCnt;
        bus.rstfull_n_in = 1'b1;
        modelRetry = 1;
        expQ.push_back('{EV_REQ, base + 3 + kTimeout + 1, modelRetry});
        cycles(3 + kTimeout + 2);
        checkOutput("reboot_req high before reset", int'(bus.reboot_req), 1);
        #5 hard_rst_n = 1'b0;
        #1;
        checkOutput("async reset reboot_req", int'(bus.reboot_req), 0);
        checkOutput("async reset retry_cnt mid-pulse", int'(bus.retry_cnt), 0);
        modelRetry       = 0;
        bus.rstfull_n_in = 1'b0;
        cycles(2);
        hard_rst_n = 1'b1;
        cycles(3);

        // Recovery boot after the reset
        applyStimulus($urandom_range(8, kTimeout - kDeb - 4), 1'b1, 0);
        cycles(5);

        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends on its own
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dsp_boot_monitor.md
DSP_BOOT_MONITOR -- requirements
Module: dsp_boot_monitor

Interface
REQ-001 Parameter BOOT_TIMEOUT, 20'hF_4240 (40 ms @ 25 MHz), SHALL set the number of cycles allowed from full-reset release to a debounced high on the DSP reset status.
REQ-002 Parameter DEB_LEN, 4'd8, SHALL set the number of consecutive synchronized-high samples that count as a debounced high.
REQ-003 Parameter MAX_RETRY, 2'd2, SHALL set the number of reboot requests issued before failure is declared.
REQ-004 Parameter REQ_LEN, 8'd16, SHALL set the reboot_req pulse width in cycles.
REQ-005 Parameter LED_HALF, 24'h5F_5E10 (250 ms), SHALL set the slow-blink half period; the fast-blink half period SHALL be LED_HALF>>2.
REQ-006 clk_sys  in  1  SHALL be the 25 MHz system clock; one clock domain.
REQ-007 hard_rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-008 rstfull_n_in  in  1  SHALL be the full-reset release from the reset sequencer (asynchronous).
REQ-009 dsp0_rstn_state  in  1  SHALL be DSP RESETSTAT#, high when the DSP is out of reset (asynchronous).
REQ-010 reboot_req  out  1  SHALL be the request to the sequencer to restart the power-on reset sequence.
REQ-011 boot_ok  out  1  SHALL be high in OK.
REQ-012 boot_fail  out  1  SHALL be high in FAIL.
REQ-013 retry_cnt  out  2  SHALL be the number of reboot requests issued since reset.
REQ-014 dsp_led_0  out  1  SHALL be the status LED, active high.

Function
REQ-015 rstfull_n_in and dsp0_rstn_state SHALL each pass through a 2-flop synchronizer; all logic SHALL use the synchronized copies (rf_s, st_s).
REQ-016 The debounce counter SHALL clear when st_s=0, increment while st_s=1, saturate at DEB_LEN; deb_hi=1 exactly when count==DEB_LEN.
REQ-017 States SHALL be IDLE, WAIT_STAT, OK, RETRY, DRAIN, FAIL.
REQ-018 IDLE: on rf_s=1 -> WAIT_STAT with the timeout counter cleared.
REQ-019 WAIT_STAT: the timeout counter SHALL increment each cycle; deb_hi=1 -> OK; counter==BOOT_TIMEOUT-1 with deb_hi=0 -> RETRY if retry_cnt<MAX_RETRY, else FAIL.
REQ-020 If deb_hi and timeout occur in the same cycle, OK SHALL win.
REQ-021 Entering RETRY SHALL increment retry_cnt (saturating at 3); reboot_req SHALL be high for exactly REQ_LEN cycles, then -> DRAIN.
REQ-022 DRAIN SHALL wait for rf_s=0 and then -> IDLE.
REQ-023 OK: if st_s=0 (DSP re-entered reset), -> WAIT_STAT with the timeout counter cleared and no retry increment.
REQ-024 In WAIT_STAT or OK, rf_s=0 (external reset) SHALL -> IDLE with no retry increment.
REQ-025 FAIL SHALL be sticky until hard_rst_n; reboot_req SHALL be 0 there.
REQ-026 Outputs SHALL be registered; boot_ok/boot_fail SHALL assert the cycle after the state register enters OK/FAIL.
REQ-027 LED behaviour by state:
- IDLE/DRAIN: 0.
- WAIT_STAT/RETRY: toggle every LED_HALF cycles.
- OK: 1.
- FAIL: toggle every LED_HALF>>2 cycles.
- The blink counter SHALL clear on every state change.

Reset
REQ-028 While hard_rst_n=0: state=IDLE, all counters 0, synchronizers 0, reboot_req=0, boot_ok=0, boot_fail=0, retry_cnt=0, dsp_led_0=0.
REQ-029 Reset assertion mid-operation, including during a reboot_req pulse, SHALL drop all outputs immediately (asynchronously).
REQ-030 Release SHALL be synchronous; the first state transition can occur on the first clock edge after release.

Structure
REQ-031 The state encoding and the default timing constants SHALL live in shared package cpld_pkg.
REQ-032 The synchronizer plus debounce SHALL be one sub-module, sync_debounce, instantiated once for dsp0_rstn_state; rstfull_n_in SHALL use a plain 2-flop synchronizer.

Verification
All scenarios SHALL use BOOT_TIMEOUT=100, DEB_LEN=4, REQ_LEN=4, LED_HALF=16, MAX_RETRY=2.
REQ-033 Normal boot: rstfull_n_in rises, dsp0_rstn_state rises 30 cycles later -> boot_ok=1 within 30+2+4+2 cycles; retry_cnt=0; LED steady 1.
REQ-034 Timeout: dsp0_rstn_state held 0 -> reboot_req high for 4 cycles, 100 cycles after WAIT_STAT entry; retry_cnt=1; after rstfull_n_in low then high, second timeout gives retry_cnt=2; third timeout gives boot_fail=1, LED toggling every 4 cycles, no further reboot_req.
REQ-035 Glitch: 3-cycle high pulses on dsp0_rstn_state -> boot_ok stays 0.
REQ-036 Tie: debounce completes on the timeout cycle (cycle 99) -> OK, no reboot_req.
REQ-037 Mid-operation events:
- rstfull_n_in low in OK -> IDLE, boot_ok=0, retry_cnt unchanged.
- hard_rst_n low during reboot_req -> reboot_req=0 immediately.
